// File: rtl/aes_stream_pkg.sv
// Shared types and constants for the AES streaming controller.
// State encoding, cipher mode codes and the completion-code helper.
package aes_stream_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RD_WAIT   = 4'd1,
    S_RD_REQ    = 4'd2,
    S_RD_LAT    = 4'd3,
    S_CIPH      = 4'd4,
    S_CIPH_WAIT = 4'd5,
    S_WR_WAIT   = 4'd6,
    S_WR_PUT    = 4'd7,
    S_DONE      = 4'd8,
    S_ERR       = 4'd9
  } state_t;

  localparam logic [1:0] MODE_ENC = 2'b10;
  localparam logic [1:0] MODE_DEC = 2'b01;
  localparam logic [1:0] MODE_BYP = 2'b00;
  localparam logic [1:0] MODE_ILL = 2'b11;
  localparam logic [1:0] DONE_BYP = 2'b11;

  function automatic logic [1:0] done_code(
    input logic [1:0] mode
  );
    return (mode == MODE_BYP) ? DONE_BYP : mode;
  endfunction

endpackage

// File: rtl/aes_word_pack.sv
// Block register with a word-slot write port and a word-slot read mux.
// Slot 0 occupies the least significant bits of the block.
module aes_word_pack #(
  parameter int DATA_W = 16,
  parameter int N      = 8,
  parameter int IDX_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                ld_en,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wr_word,
  input  logic [N*DATA_W-1:0] ld_block,
  output logic [DATA_W-1:0]   rd_word,
  output logic [N*DATA_W-1:0] block
);

  logic [N-1:0][DATA_W-1:0] slot_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else if (ld_en) begin
      slot_q <= ld_block;
    end else if (wr_en) begin
      slot_q[idx] <= wr_word;
    end
  end

  assign rd_word = slot_q[idx];
  assign block   = slot_q;

endmodule

// File: rtl/aes_stream_ctrl.sv
// Streams FIFO words through an external block cipher core.
// Packs N words per block, waits for the result, unpacks it to the write FIFO.
module aes_stream_ctrl
  import aes_stream_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int BLOCK_W = 128,
  parameter int CNT_W   = 20,
  parameter int USE_W   = 16,
  parameter int WR_HIGH = 256,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iSTART,
  input  logic [1:0]         iMODE,
  input  logic [CNT_W-1:0]   iNUM_BLOCKS,
  input  logic [USE_W-1:0]   iRD_USE,
  input  logic               iRD_BUSY,
  output logic               oRD,
  input  logic [DATA_W-1:0]  iRD_DATA,
  input  logic [USE_W-1:0]   iWR_USE,
  input  logic               iWR_BUSY,
  output logic               oWR,
  output logic [DATA_W-1:0]  oWR_DATA,
  output logic               oCIPH_LD,
  output logic               oCIPH_KLD,
  output logic [BLOCK_W-1:0] oCIPH_TEXT,
  input  logic               iCIPH_DONE,
  input  logic [BLOCK_W-1:0] iCIPH_TEXT,
  output logic               oBUSY,
  output logic [1:0]         oDONE,
  output logic               oERR,
  output logic [CNT_W-1:0]   oBLK_CNT,
  output logic [3:0]         oSTATE
);

  localparam int N     = BLOCK_W / DATA_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [USE_W-1:0] RD_MIN   = USE_W'(N);
  localparam logic [USE_W-1:0] WR_MAX   = USE_W'(WR_HIGH - N);

  state_t             state_q;
  state_t             state_d;
  logic               start_q;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   num_q;
  logic [IDX_W-1:0]   idx_q;
  logic [LAT_W-1:0]   lat_q;
  logic [TO_W-1:0]    wait_q;
  logic [CNT_W-1:0]   blk_cnt_q;
  logic [1:0]         done_q;
  logic               first_q;

  logic               start_ok;
  logic               rd_cap;
  logic               wr_step;
  logic               last_word;
  logic               blk_fin;
  logic               run_end;
  logic               res_ld;
  logic [CNT_W-1:0]   blk_next;
  logic [DATA_W-1:0]  in_word;
  logic [DATA_W-1:0]  res_word;
  logic [BLOCK_W-1:0] in_block;
  logic [BLOCK_W-1:0] res_block_unused;

  assign start_ok  = iSTART && !start_q &&
                     (state_q == S_IDLE || state_q == S_DONE);
  assign rd_cap    = (state_q == S_RD_LAT) && (lat_q == LAT_LAST);
  assign wr_step   = (state_q == S_WR_PUT);
  assign last_word = (idx_q == IDX_LAST);
  assign blk_next  = blk_cnt_q + 1'b1;
  assign blk_fin   = wr_step && last_word;
  assign run_end   = blk_fin && (blk_next == num_q);
  assign res_ld    = (state_q == S_CIPH_WAIT) && iCIPH_DONE;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          if (iMODE == MODE_ILL) begin
            state_d = S_ERR;
          end else if (iNUM_BLOCKS == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (iRD_USE >= RD_MIN && !iRD_BUSY) begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: state_d = S_RD_LAT;
      S_RD_LAT: begin
        if (rd_cap) begin
          if (!last_word) begin
            state_d = S_RD_REQ;
          end else if (mode_q == MODE_BYP) begin
            state_d = S_WR_WAIT;
          end else begin
            state_d = S_CIPH;
          end
        end
      end
      S_CIPH: state_d = S_CIPH_WAIT;
      S_CIPH_WAIT: begin
        if (iCIPH_DONE) begin
          state_d = S_WR_WAIT;
        end else if (wait_q == TO_LAST) begin
          state_d = S_ERR;
        end
      end
      S_WR_WAIT: begin
        if (iWR_USE <= WR_MAX && !iWR_BUSY) begin
          state_d = S_WR_PUT;
        end
      end
      S_WR_PUT: begin
        if (last_word) begin
          state_d = run_end ? S_DONE : S_RD_WAIT;
        end
      end
      S_ERR: state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // wait_q counts cycles since the load pulse, starting at 1 in CIPH_WAIT
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      start_q   <= 1'b1;
      mode_q    <= '0;
      num_q     <= '0;
      idx_q     <= '0;
      lat_q     <= '0;
      wait_q    <= '0;
      blk_cnt_q <= '0;
      done_q    <= '0;
      first_q   <= 1'b0;
    end else begin
      start_q <= iSTART;
      if (start_ok) begin
        mode_q    <= iMODE;
        num_q     <= iNUM_BLOCKS;
        idx_q     <= '0;
        blk_cnt_q <= '0;
        first_q   <= 1'b1;
        done_q    <= (iMODE != MODE_ILL && iNUM_BLOCKS == '0) ?
                     done_code(iMODE) : 2'b00;
      end
      if (state_q == S_RD_REQ) begin
        lat_q <= '0;
      end
      if (state_q == S_RD_LAT) begin
        lat_q <= lat_q + 1'b1;
      end
      if (rd_cap || wr_step) begin
        idx_q <= last_word ? '0 : idx_q + 1'b1;
      end
      if (state_q == S_CIPH) begin
        wait_q  <= TO_W'(1);
        first_q <= 1'b0;
      end
      if (state_q == S_CIPH_WAIT) begin
        wait_q <= wait_q + 1'b1;
      end
      if (blk_fin) begin
        blk_cnt_q <= blk_next;
      end
      if (run_end) begin
        done_q <= done_code(mode_q);
      end
    end
  end

  aes_word_pack #(
    .DATA_W (DATA_W),
    .N      (N),
    .IDX_W  (IDX_W)
  ) u_in_pack (
    .clk      (iCLK),
    .rst      (iRST),
    .wr_en    (rd_cap),
    .ld_en    (1'b0),
    .idx      (idx_q),
    .wr_word  (iRD_DATA),
    .ld_block ('0),
    .rd_word  (in_word),
    .block    (in_block)
  );

  aes_word_pack #(
    .DATA_W (DATA_W),
    .N      (N),
    .IDX_W  (IDX_W)
  ) u_res_pack (
    .clk      (iCLK),
    .rst      (iRST),
    .wr_en    (1'b0),
    .ld_en    (res_ld),
    .idx      (idx_q),
    .wr_word  ('0),
    .ld_block (iCIPH_TEXT),
    .rd_word  (res_word),
    .block    (res_block_unused)
  );

  assign oRD        = (state_q == S_RD_REQ);
  assign oWR        = wr_step;
  assign oWR_DATA   = !wr_step ? '0 :
                      (mode_q == MODE_BYP) ? in_word : res_word;
  assign oCIPH_LD   = (state_q == S_CIPH);
  assign oCIPH_KLD  = oCIPH_LD && first_q && (mode_q == MODE_DEC);
  assign oCIPH_TEXT = in_block;
  assign oBUSY      = !(state_q == S_IDLE || state_q == S_DONE ||
                        state_q == S_ERR);
  assign oDONE      = done_q;
  assign oERR       = (state_q == S_ERR);
  assign oBLK_CNT   = blk_cnt_q;
  assign oSTATE     = state_q;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Randomised bench for aes_stream_ctrl with a word/block-level model.
// Environment models the FIFOs and an inverting cipher core.
module tb_aes_stream_ctrl;

  localparam int DW      = 16;
  localparam int BW      = 128;
  localparam int N       = BW / DW;
  localparam int CW      = 20;
  localparam int UW      = 16;
  localparam int WR_HIGH = 256;
  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 255;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iSTART;
  logic [1:0]    iMODE;
  logic [CW-1:0] iNUM_BLOCKS;
  logic [UW-1:0] iRD_USE;
  logic          iRD_BUSY;
  logic          oRD;
  logic [DW-1:0] iRD_DATA;
  logic [UW-1:0] iWR_USE;
  logic          iWR_BUSY;
  logic          oWR;
  logic [DW-1:0] oWR_DATA;
  logic          oCIPH_LD;
  logic          oCIPH_KLD;
  logic [BW-1:0] oCIPH_TEXT;
  logic          iCIPH_DONE;
  logic [BW-1:0] iCIPH_TEXT;
  logic          oBUSY;
  logic [1:0]    oDONE;
  logic          oERR;
  logic [CW-1:0] oBLK_CNT;
  logic [3:0]    oSTATE;

  aes_stream_ctrl #(
    .DATA_W  (DW),
    .BLOCK_W (BW),
    .CNT_W   (CW),
    .USE_W   (UW),
    .WR_HIGH (WR_HIGH),
    .RD_LAT  (RD_LAT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iSTART      (iSTART),
    .iMODE       (iMODE),
    .iNUM_BLOCKS (iNUM_BLOCKS),
    .iRD_USE     (iRD_USE),
    .iRD_BUSY    (iRD_BUSY),
    .oRD         (oRD),
    .iRD_DATA    (iRD_DATA),
    .iWR_USE     (iWR_USE),
    .iWR_BUSY    (iWR_BUSY),
    .oWR         (oWR),
    .oWR_DATA    (oWR_DATA),
    .oCIPH_LD    (oCIPH_LD),
    .oCIPH_KLD   (oCIPH_KLD),
    .oCIPH_TEXT  (oCIPH_TEXT),
    .iCIPH_DONE  (iCIPH_DONE),
    .iCIPH_TEXT  (iCIPH_TEXT),
    .oBUSY       (oBUSY),
    .oDONE       (oDONE),
    .oERR        (oERR),
    .oBLK_CNT    (oBLK_CNT),
    .oSTATE      (oSTATE)
  );

  always #5 iCLK = ~iCLK;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  bit            rand_flow = 0;
  bit            ciph_hang = 0;
  bit            quiet     = 0;
  bit            prev_rd_ok;
  bit            prev_wr_ok;
  logic [1:0]    run_mode;
  int            rd_in_run, wr_in_run, ld_in_run, kld_count;
  int            rd_pend, ciph_cnt;
  int            wr_first, wr_last, ld_cyc;
  logic [DW-1:0] next_rd_word;
  logic [DW-1:0] rd_data_nxt;
  logic [DW-1:0] cur_words [N];
  logic [BW-1:0] cur_blk;
  logic [BW-1:0] first_txt;
  logic [BW-1:0] ciph_res;
  logic [DW-1:0] w, e;
  logic [DW-1:0] exp_wr [$];
  logic [DW-1:0] wr_log [$];

  task automatic chk(input string nm, input logic [BW-1:0] act,
                     input logic [BW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  always @(posedge iCLK) begin
    cyc        <= cyc + 1;
    prev_rd_ok <= (iRD_USE >= UW'(N)) && !iRD_BUSY;
    prev_wr_ok <= (iWR_USE <= UW'(WR_HIGH - N)) && !iWR_BUSY;
  end

  always @(negedge iCLK) begin
    if (rand_flow) begin
      iRD_USE  = UW'($urandom_range(0, 15));
      iRD_BUSY = ($urandom_range(0, 3) == 0);
      iWR_USE  = UW'($urandom_range(244, 256));
      iWR_BUSY = ($urandom_range(0, 3) == 0);
    end
    if (oRD) begin
      if (rd_in_run % N == 0) chk("rd_gate", prev_rd_ok, 1);
      w = next_rd_word;
      next_rd_word = next_rd_word + 1'b1;
      cur_words[rd_in_run % N] = w;
      rd_in_run++;
      if (rd_in_run % N == 0) begin
        for (int k = 0; k < N; k++) begin
          cur_blk[k*DW +: DW] = cur_words[k];
          exp_wr.push_back(run_mode == 2'b00 ? cur_words[k] : ~cur_words[k]);
        end
      end
      rd_data_nxt = w;
      rd_pend = RD_LAT;
      iRD_DATA = DW'($urandom);
    end else if (rd_pend > 0) begin
      rd_pend--;
      if (rd_pend == 0) iRD_DATA = rd_data_nxt;
    end
    if (iCIPH_DONE) iCIPH_DONE = 1'b0;
    if (oCIPH_LD) begin
      chk("ciph_text", oCIPH_TEXT, cur_blk);
      chk("kld", oCIPH_KLD, (run_mode == 2'b01 && ld_in_run == 0));
      if (ld_in_run == 0) first_txt = oCIPH_TEXT;
      if (oCIPH_KLD) kld_count++;
      ld_in_run++;
      ld_cyc = cyc;
      ciph_res = ~oCIPH_TEXT;
      ciph_cnt = 10;
      iCIPH_DONE = 1'b1;
      iCIPH_TEXT = {$urandom, $urandom, $urandom, $urandom};
    end else if (ciph_cnt > 0) begin
      ciph_cnt--;
      if (ciph_cnt == 0 && !ciph_hang) begin
        iCIPH_DONE = 1'b1;
        iCIPH_TEXT = ciph_res;
      end
    end
    if (oCIPH_KLD) chk("kld_with_ld", oCIPH_LD, 1);
    if (oWR) begin
      if (wr_in_run % N == 0) begin
        chk("wr_gate", prev_wr_ok, 1);
        wr_first = cyc;
      end
      wr_last = cyc;
      chk("blk_cnt_run", oBLK_CNT, wr_in_run / N);
      chk("wr_expected", exp_wr.size() != 0, 1);
      if (exp_wr.size() != 0) begin
        e = exp_wr.pop_front();
        chk("wr_data", oWR_DATA, e);
      end
      wr_log.push_back(oWR_DATA);
      wr_in_run++;
    end
    if (oRD || oWR) chk("rd_wr_excl", oRD & oWR, 0);
    if (quiet) chk("quiet_io", {oRD, oWR}, 0);
  end

  task automatic model_clear();
    rd_in_run = 0; wr_in_run = 0; ld_in_run = 0; kld_count = 0;
    rd_pend = 0; ciph_cnt = 0;
    exp_wr.delete();
    wr_log.delete();
  endtask

  task automatic start_run(input logic [1:0] m, input int nb);
    @(negedge iCLK);
    iMODE = m;
    iNUM_BLOCKS = CW'(nb);
    iSTART = 1'b1;
    run_mode = m;
    model_clear();
    @(negedge iCLK);
    iSTART = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge iCLK);
      if (oDONE != 2'b00 || oERR) ok = 1;
    end
    chk("run_finished", ok, 1);
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    iRST = 1'b1;
    repeat (2) @(negedge iCLK);
    model_clear();
    iRST = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int nb, err_cyc, bit_ok;
    logic [1:0] m;
    iRST = 1'b1; iSTART = 1'b1; iMODE = 2'b00; iNUM_BLOCKS = '0;
    iRD_USE = '0; iRD_BUSY = 1'b0; iRD_DATA = '0;
    iWR_USE = '0; iWR_BUSY = 1'b0;
    iCIPH_DONE = 1'b0; iCIPH_TEXT = '0;
    next_rd_word = 16'h0001; run_mode = 2'b00;
    cur_blk = '0; first_txt = '0;
    model_clear();

    repeat (3) @(negedge iCLK);
    chk("rst_text", oCIPH_TEXT, 0);
    chk("rst_ctl", {oRD, oWR, oWR_DATA, oCIPH_LD, oCIPH_KLD, oBUSY,
                    oDONE, oERR, oBLK_CNT, oSTATE}, 0);
    iRST = 1'b0;
    repeat (5) @(negedge iCLK);
    chk("held_start_idle", {oBUSY, oSTATE}, 0);
    iSTART = 1'b0;

    iRD_USE = 16; iWR_USE = 0;
    next_rd_word = 16'h0001;
    start_run(2'b10, 2);
    wait_end(1000);
    chk("enc_first_txt", first_txt,
        128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("enc_nwords", wr_log.size(), 16);
    if (wr_log.size() == 16) begin
      chk("enc_word0", wr_log[0], 16'hFFFE);
      chk("enc_word15", wr_log[15], 16'hFFEF);
    end
    chk("enc_blk_cnt", oBLK_CNT, 2);
    chk("enc_done", oDONE, 2'b10);
    chk("enc_busy", oBUSY, 0);

    rand_flow = 1;
    start_run(2'b01, 3);
    wait_end(3000);
    chk("dec_kld_count", kld_count, 1);
    chk("dec_done", oDONE, 2'b01);
    chk("dec_blk_cnt", oBLK_CNT, 3);

    rand_flow = 0;
    iRD_USE = 16; iRD_BUSY = 0; iWR_BUSY = 0; iWR_USE = 251;
    start_run(2'b00, 1);
    repeat (60) @(negedge iCLK);
    chk("byp_stall_no_wr", wr_in_run, 0);
    chk("byp_stall_busy", oBUSY, 1);
    iWR_USE = 248;
    wait_end(200);
    chk("byp_nwords", wr_in_run, 8);
    chk("byp_consecutive", wr_last - wr_first, 7);
    chk("byp_done", oDONE, 2'b11);
    chk("byp_left", exp_wr.size(), 0);

    rand_flow = 1;
    for (int r = 0; r < 6; r++) begin
      m = 2'($urandom_range(0, 2));
      nb = $urandom_range(1, 3);
      start_run(m, nb);
      wait_end(3000);
      chk("rnd_done", oDONE, (m == 2'b00) ? 2'b11 : m);
      chk("rnd_blk_cnt", oBLK_CNT, nb);
      chk("rnd_left", exp_wr.size(), 0);
      chk("rnd_busy", oBUSY, 0);
    end
    rand_flow = 0;
    iRD_USE = 16; iRD_BUSY = 0; iWR_USE = 0; iWR_BUSY = 0;

    start_run(2'b10, 0);
    chk("zero_done", oDONE, 2'b10);
    chk("zero_busy", oBUSY, 0);

    ciph_hang = 1;
    start_run(2'b10, 1);
    bit_ok = 0;
    err_cyc = 0;
    for (int i = 0; i < 600 && !bit_ok; i++) begin
      @(negedge iCLK);
      if (oERR) begin
        bit_ok = 1;
        err_cyc = cyc;
      end
    end
    chk("to_reached", bit_ok, 1);
    chk("to_cycles", err_cyc - ld_cyc, TIMEOUT);
    chk("to_busy", oBUSY, 0);
    @(negedge iCLK);
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    repeat (5) @(negedge iCLK);
    chk("to_sticky", {oERR, oBUSY, oRD}, 3'b100);
    do_reset();
    chk("to_cleared", {oERR, oSTATE}, 0);
    ciph_hang = 0;

    start_run(2'b11, 1);
    chk("ill_err", oERR, 1);
    chk("ill_busy", oBUSY, 0);
    do_reset();

    start_run(2'b10, 2);
    bit_ok = 0;
    for (int i = 0; i < 200 && !bit_ok; i++) begin
      @(negedge iCLK);
      if (rd_in_run == 5) bit_ok = 1;
    end
    chk("mid_reached", bit_ok, 1);
    @(negedge iCLK);
    iRST = 1'b1;
    quiet = 1;
    @(negedge iCLK);
    chk("mid_rst_text", oCIPH_TEXT, 0);
    chk("mid_rst_ctl", {oRD, oWR, oWR_DATA, oCIPH_LD, oCIPH_KLD, oBUSY,
                        oDONE, oERR, oBLK_CNT, oSTATE}, 0);
    @(negedge iCLK);
    iRST = 1'b0;
    model_clear();
    repeat (20) @(negedge iCLK);
    chk("mid_idle", {oBUSY, oSTATE}, 0);
    quiet = 0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
